flex_down_counter: RTL and testbench
====================================

// Module: flex_down_counter
// PURPOSE
//   Loadable, parameterised down-counter/interval timer; the counting-down
//   counterpart of the flex up-counter. Loads a start value, decrements on
//   count_enable and flags expiry. One-shot or periodic (auto-reload) mode.
//   Used to time bit periods and timeouts alongside flex counters.
// PARAMETERS
//   NUM_CNT_BITS  16  width of count_out, load_val and the internal reload register
// PORTS
//   clk           in   1             system clock; all state changes on rising edge
//   rst           in   1             synchronous active-high reset
//   clear         in   1             synchronous clear to IDLE (keeps reload register)
//   load          in   1             load strobe; captures load_val this edge
//   load_val      in   NUM_CNT_BITS  start/reload value
//   count_enable  in   1             decrement enable
//   auto_reload   in   1             1 = periodic, 0 = one-shot
//   count_out     out  NUM_CNT_BITS  current count
//   expired       out  1             1-cycle registered pulse on terminal count
//   busy          out  1             state == RUN
//   done          out  1             state == DONE (one-shot finished)
// BEHAVIOUR
//   Interface: one clock; reset is synchronous and active-high.
//   All outputs registered; no combinational input->output paths.
//   Reset (rst=1 at edge): state IDLE, count_out=0, reload_reg=0,
//     expired=0, busy=0, done=0. Reset held = values held; mid-count reset aborts.
//   Priority per edge: rst > clear > load > decrement.
//   States: IDLE, RUN, DONE.
//   clear: state IDLE, count_out=0, expired=0; reload_reg unchanged.
//   load (any state): reload_reg<=load_val; count_out<=load_val;
//     load_val!=0 -> RUN; load_val==0 -> IDLE (no expired). expired=0.
//   RUN, count_enable=0: hold count_out; expired=0.
//   RUN, count_enable=1, count_out>1: count_out<=count_out-1; expired=0.
//   RUN, count_enable=1, count_out==1 (terminal):
//     auto_reload=1 -> count_out<=reload_reg, stay RUN, expired=1;
//     auto_reload=0 -> count_out<=0, go DONE, expired=1.
//     auto_reload sampled on the terminal edge only. Period = reload_reg enables.
//   expired high exactly the one cycle after the terminal edge; low otherwise.
//   IDLE/DONE: count_enable ignored, count_out held; exit only via load or rst.
//   load coincident with terminal decrement: load wins, expired=0.
//   clear coincident with load: clear wins, reload_reg not updated.
//   Max value: load_val=2^NUM_CNT_BITS-1 valid; never wraps below 0.
// TESTING
//   T1 reset: rst=1 2 cycles mid-RUN -> count_out=0, busy=0, done=0, expired=0.
//   T2 one-shot: load 25, auto_reload=0, enable -> 25,24..1,0; expired=1 one
//      cycle with count_out=0; done=1; further enables keep 0.
//   T3 periodic: load 2, auto_reload=1, enable -> 2,1,2,1,2; expired=1 on each
//      cycle count returns to 2 (not after load), 0 never seen.
//   T4 discontinuous: load 4, enable 2 cycles (->2), disable 1 (hold 2),
//      enable 2 (->1, then expire); expired only after terminal edge.
//   T5 clear/priority: load 4, count to 3, assert clear+load(9) -> IDLE, count 0;
//      then load 9 -> 9; load 7 on terminal edge -> 7, expired=0.
//   T6 edge values: load 0 -> IDLE, no expired; load 16'hFFFF, enable -> 16'hFFFE.

Source files
------------

// File: rtl/flex_down_counter.sv
// -----------------------------------------------------------------------------
// flex_down_counter
//   Loadable down-counter / interval timer. A load captures a start value into
//   both the live count and a reload register. The counter then decrements on
//   count_enable and flags expiry when it passes through 1. In one-shot mode it
//   parks in DONE at zero. In periodic mode it reloads from the reload register
//   and keeps running.
//
// Ports
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   clear         synchronous return to IDLE; the reload register is kept
//   load          load strobe, captures load_val on this edge
//   load_val      start / reload value
//   count_enable  decrement enable (only honoured in RUN)
//   auto_reload   1 = periodic, 0 = one-shot (sampled on the terminal edge)
//   count_out     current count (registered)
//   expired       one-cycle registered pulse after the terminal edge
//   busy          registered, high while in RUN
//   done          registered, high while in DONE
// -----------------------------------------------------------------------------
module flex_down_counter #(
    parameter int NUM_CNT_BITS = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    load,
    input  logic [NUM_CNT_BITS-1:0] load_val,
    input  logic                    count_enable,
    input  logic                    auto_reload,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    expired,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [NUM_CNT_BITS-1:0] CNT_ZERO = {NUM_CNT_BITS{1'b0}};
    localparam logic [NUM_CNT_BITS-1:0] CNT_ONE  = {{(NUM_CNT_BITS-1){1'b0}}, 1'b1};

    state_t                  state_r;
    state_t                  next_state_s;
    logic [NUM_CNT_BITS-1:0] count_r;
    logic [NUM_CNT_BITS-1:0] next_count_s;
    logic [NUM_CNT_BITS-1:0] reload_r;
    logic [NUM_CNT_BITS-1:0] next_reload_s;
    logic                    expired_r;
    logic                    next_expired_s;
    logic                    busy_r;
    logic                    done_r;

    // Next-state decode; priority is clear > load > decrement.
    always_comb begin
        next_state_s   = state_r;
        next_count_s   = count_r;
        next_reload_s  = reload_r;
        next_expired_s = 1'b0;

        if (clear) begin
            next_state_s = ST_IDLE;
            next_count_s = CNT_ZERO;
        end else if (load) begin
            // A zero load would expire immediately; park in IDLE instead.
            next_reload_s = load_val;
            next_count_s  = load_val;
            if (load_val != CNT_ZERO) begin
                next_state_s = ST_RUN;
            end else begin
                next_state_s = ST_IDLE;
            end
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (count_enable) begin
                        if (count_r > CNT_ONE) begin
                            next_count_s = count_r - CNT_ONE;
                        end else if (count_r == CNT_ONE) begin
                            // Terminal edge: the pulse appears the following cycle.
                            next_expired_s = 1'b1;
                            if (auto_reload) begin
                                next_count_s = reload_r;
                                next_state_s = ST_RUN;
                            end else begin
                                next_count_s = CNT_ZERO;
                                next_state_s = ST_DONE;
                            end
                        end else begin
                            // Zero in RUN is unreachable; hold rather than wrap.
                            next_count_s = count_r;
                        end
                    end else begin
                        next_count_s = count_r;
                    end
                end
                ST_IDLE: begin
                    next_state_s = ST_IDLE;
                end
                ST_DONE: begin
                    next_state_s = ST_DONE;
                end
                default: begin
                    next_state_s = ST_IDLE;
                    next_count_s = CNT_ZERO;
                end
            endcase
        end
    end

    // State, count, reload and status registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            count_r   <= CNT_ZERO;
            reload_r  <= CNT_ZERO;
            expired_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= next_state_s;
            count_r   <= next_count_s;
            reload_r  <= next_reload_s;
            expired_r <= next_expired_s;
            busy_r    <= (next_state_s == ST_RUN);
            done_r    <= (next_state_s == ST_DONE);
        end
    end

    assign count_out = count_r;
    assign expired   = expired_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_flex_down_counter.sv
// -----------------------------------------------------------------------------
// tb_flex_down_counter
//   Directed self-checking bench for flex_down_counter (16-bit). Inputs change
//   1 ns after each rising edge and outputs are checked at that same point.
// -----------------------------------------------------------------------------
module tb_flex_down_counter;

    localparam int W = 16;

    logic         tb_clk;
    logic         rst;
    logic         clear;
    logic         load;
    logic [W-1:0] load_val;
    logic         count_enable;
    logic         auto_reload;
    logic [W-1:0] count_out;
    logic         expired;
    logic         busy;
    logic         done;

    int checks;
    int errors;

    flex_down_counter #(.NUM_CNT_BITS(W)) dut (
        .clk          (tb_clk),
        .rst          (rst),
        .clear        (clear),
        .load         (load),
        .load_val     (load_val),
        .count_enable (count_enable),
        .auto_reload  (auto_reload),
        .count_out    (count_out),
        .expired      (expired),
        .busy         (busy),
        .done         (done)
    );

    // Free-running clock, 10 ns period.
    initial begin
        tb_clk = 1'b0;
        forever #5 tb_clk = ~tb_clk;
    end

    task automatic tick();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst          = 1'b0;
        clear        = 1'b0;
        load         = 1'b0;
        load_val     = 16'h0000;
        count_enable = 1'b0;
        auto_reload  = 1'b0;
    endtask

    task automatic do_load(input logic [W-1:0] v);
        load     = 1'b1;
        load_val = v;
        tick();
        load     = 1'b0;
        load_val = 16'h0000;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if ({count_out, expired, busy, done} !== {16'h0000, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_init: got cnt=%h exp=%b busy=%b done=%b want 0000 0 0 0",
                     count_out, expired, busy, done);
        end
        // Reset in the middle of a run aborts it.
        do_load(16'd10);
        count_enable = 1'b1;
        tick();
        tick();
        checks++;
        if (count_out !== 16'd8 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_prerun: got cnt=%0d busy=%b want 8 1", count_out, busy);
        end
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({count_out, expired, busy, done} !== {16'h0000, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_midrun: got cnt=%h exp=%b busy=%b done=%b want 0000 0 0 0",
                     count_out, expired, busy, done);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (count_out !== 16'h0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: got cnt=%0d busy=%b want 0 0", count_out, busy);
        end
        idle_inputs();
    endtask

    task automatic test_one_shot();
        idle_inputs();
        do_load(16'd25);
        checks++;
        if (count_out !== 16'd25 || busy !== 1'b1 || expired !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_load: got cnt=%0d busy=%b exp=%b want 25 1 0",
                     count_out, busy, expired);
        end
        count_enable = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            tick();
            checks++;
            if (count_out !== 16'(25 - k) || expired !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL oneshot_step%0d: got cnt=%0d exp=%b busy=%b want %0d 0 1",
                         k, count_out, expired, busy, 25 - k);
            end
        end
        tick();
        checks++;
        if ({count_out, expired, busy, done} !== {16'h0000, 1'b1, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL oneshot_expire: got cnt=%0d exp=%b busy=%b done=%b want 0 1 0 1",
                     count_out, expired, busy, done);
        end
        tick();
        tick();
        checks++;
        if ({count_out, expired, busy, done} !== {16'h0000, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL oneshot_hold_done: got cnt=%0d exp=%b busy=%b done=%b want 0 0 0 1",
                     count_out, expired, busy, done);
        end
        idle_inputs();
    endtask

    task automatic test_periodic();
        logic [W-1:0] exp_cnt [4];
        logic         exp_pls [4];
        exp_cnt[0] = 16'd1; exp_pls[0] = 1'b0;
        exp_cnt[1] = 16'd2; exp_pls[1] = 1'b1;
        exp_cnt[2] = 16'd1; exp_pls[2] = 1'b0;
        exp_cnt[3] = 16'd2; exp_pls[3] = 1'b1;
        idle_inputs();
        auto_reload = 1'b1;
        do_load(16'd2);
        checks++;
        if (count_out !== 16'd2 || expired !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL periodic_load: got cnt=%0d exp=%b busy=%b want 2 0 1",
                     count_out, expired, busy);
        end
        count_enable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (count_out !== exp_cnt[k] || expired !== exp_pls[k] || busy !== 1'b1) begin
                errors++;
                $display("FAIL periodic_step%0d: got cnt=%0d exp=%b busy=%b want %0d %b 1",
                         k, count_out, expired, busy, exp_cnt[k], exp_pls[k]);
            end
        end
        idle_inputs();
    endtask

    task automatic test_discontinuous();
        idle_inputs();
        do_load(16'd4);
        count_enable = 1'b1;
        tick();
        tick();
        checks++;
        if (count_out !== 16'd2 || expired !== 1'b0) begin
            errors++;
            $display("FAIL disc_two: got cnt=%0d exp=%b want 2 0", count_out, expired);
        end
        count_enable = 1'b0;
        tick();
        checks++;
        if (count_out !== 16'd2 || expired !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL disc_hold: got cnt=%0d exp=%b busy=%b want 2 0 1",
                     count_out, expired, busy);
        end
        count_enable = 1'b1;
        tick();
        checks++;
        if (count_out !== 16'd1 || expired !== 1'b0) begin
            errors++;
            $display("FAIL disc_one: got cnt=%0d exp=%b want 1 0", count_out, expired);
        end
        tick();
        checks++;
        if (count_out !== 16'd0 || expired !== 1'b1 || done !== 1'b1) begin
            errors++;
            $display("FAIL disc_expire: got cnt=%0d exp=%b done=%b want 0 1 1",
                     count_out, expired, done);
        end
        idle_inputs();
    endtask

    task automatic test_clear_priority();
        idle_inputs();
        do_load(16'd4);
        count_enable = 1'b1;
        tick();
        checks++;
        if (count_out !== 16'd3) begin
            errors++;
            $display("FAIL clr_pre: got cnt=%0d want 3", count_out);
        end
        clear    = 1'b1;
        load     = 1'b1;
        load_val = 16'd9;
        tick();
        clear = 1'b0;
        load  = 1'b0;
        checks++;
        if ({count_out, busy, done, expired} !== {16'h0000, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL clr_over_load: got cnt=%0d busy=%b done=%b exp=%b want 0 0 0 0",
                     count_out, busy, done, expired);
        end
        // IDLE ignores count_enable.
        tick();
        checks++;
        if (count_out !== 16'h0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_ignores_en: got cnt=%0d busy=%b want 0 0", count_out, busy);
        end
        count_enable = 1'b0;
        do_load(16'd9);
        checks++;
        if (count_out !== 16'd9 || busy !== 1'b1) begin
            errors++;
            $display("FAIL clr_reload9: got cnt=%0d busy=%b want 9 1", count_out, busy);
        end
        count_enable = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        checks++;
        if (count_out !== 16'd1) begin
            errors++;
            $display("FAIL term_pre: got cnt=%0d want 1", count_out);
        end
        load     = 1'b1;
        load_val = 16'd7;
        tick();
        load = 1'b0;
        count_enable = 1'b0;
        checks++;
        if (count_out !== 16'd7 || expired !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL load_on_terminal: got cnt=%0d exp=%b busy=%b done=%b want 7 0 1 0",
                     count_out, expired, busy, done);
        end
        tick();
        checks++;
        if (expired !== 1'b0 || count_out !== 16'd7) begin
            errors++;
            $display("FAIL load_on_terminal_after: got cnt=%0d exp=%b want 7 0", count_out, expired);
        end
        idle_inputs();
    endtask

    task automatic test_edge_values();
        idle_inputs();
        do_load(16'd0);
        checks++;
        if ({count_out, busy, done, expired} !== {16'h0000, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL load_zero: got cnt=%0d busy=%b done=%b exp=%b want 0 0 0 0",
                     count_out, busy, done, expired);
        end
        count_enable = 1'b1;
        tick();
        checks++;
        if (expired !== 1'b0 || count_out !== 16'h0000) begin
            errors++;
            $display("FAIL load_zero_after: got cnt=%0d exp=%b want 0 0", count_out, expired);
        end
        count_enable = 1'b0;
        do_load(16'hFFFF);
        checks++;
        if (count_out !== 16'hFFFF || busy !== 1'b1) begin
            errors++;
            $display("FAIL load_max: got cnt=%h busy=%b want ffff 1", count_out, busy);
        end
        count_enable = 1'b1;
        tick();
        checks++;
        if (count_out !== 16'hFFFE || expired !== 1'b0) begin
            errors++;
            $display("FAIL max_dec: got cnt=%h exp=%b want fffe 0", count_out, expired);
        end
        idle_inputs();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        idle_inputs();
        test_reset();
        test_one_shot();
        test_periodic();
        test_discontinuous();
        test_clear_priority();
        test_edge_values();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
